// File: rtl/ltssm_pkg.sv
// ltssm_pkg: constants and helper functions shared by the TX ordered-set
// encoder and the RX ordered-set decoder.  The per-generation PIPE widths
// live here rather than as module parameters, so both sides of the link
// always agree on the beat geometry.
package ltssm_pkg;

    // Per-lane PIPE bits per beat for each generation, and the data bus width.
    localparam int GEN1_PIPEWIDTH = 64;
    localparam int GEN2_PIPEWIDTH = 8;
    localparam int GEN3_PIPEWIDTH = 8;
    localparam int GEN4_PIPEWIDTH = 8;
    localparam int GEN5_PIPEWIDTH = 8;
    localparam int BUS_WIDTH      = 512;

    // Number of symbols in one ordered set.
    localparam int OS_SYMBOLS = 16;

    // Ordered-set symbol constants.
    localparam logic [7:0] COM      = 8'hBC;
    localparam logic [7:0] SKP      = 8'h1C;
    localparam logic [7:0] gen3TS1  = 8'h1E;
    localparam logic [7:0] gen3TS2  = 8'h2D;
    localparam logic [7:0] gen3SKIP = 8'hAA;
    localparam logic [7:0] SDS      = 8'hE1;

    // Ordered-set type encodings carried alongside the OS.
    typedef enum logic [1:0] {
        OS_TYPE_TS1    = 2'b00,
        OS_TYPE_TS2    = 2'b01,
        OS_TYPE_OTHER  = 2'b10,
        OS_TYPE_OTHER2 = 2'b11
    } os_type_e;

    // Map a detected lane count to log2(lanes).  Any unsupported count
    // collapses to a single lane so the datapath still produces sane beats.
    function automatic logic [2:0] lanes_to_shift(input logic [4:0] lanes);
        logic [2:0] shift;
        case (lanes)
            5'd1:    shift = 3'd0;
            5'd2:    shift = 3'd1;
            5'd4:    shift = 3'd2;
            5'd8:    shift = 3'd3;
            5'd16:   shift = 3'd4;
            default: shift = 3'd0;
        endcase
        return shift;
    endfunction

    // Beat width in bits: per-lane PIPE width times the lane count, capped
    // at the bus width.  Generation codes outside 1..5 use the Gen1 width.
    function automatic logic [9:0] beat_width(input logic [2:0] gen,
                                              input logic [2:0] shift);
        logic [11:0] base;
        logic [11:0] wide;
        case (gen)
            3'd2:    base = 12'(GEN2_PIPEWIDTH);
            3'd3:    base = 12'(GEN3_PIPEWIDTH);
            3'd4:    base = 12'(GEN4_PIPEWIDTH);
            3'd5:    base = 12'(GEN5_PIPEWIDTH);
            default: base = 12'(GEN1_PIPEWIDTH);
        endcase
        wide = base << shift;
        if (wide > 12'(BUS_WIDTH)) begin
            wide = 12'(BUS_WIDTH);
        end
        return wide[9:0];
    endfunction

endpackage

// File: rtl/os_lane_striper.sv
// os_lane_striper: purely combinational byte-striping of one held ordered
// set onto the PIPE data bus.  Byte k of the beat belongs to lane k mod N
// and carries symbol symIdx + k/N; bytes past the beat width are zero.
// Build option LANE_NUM_INSERT_EN: when defined, symbol 2 of TS1/TS2 sets
// is replaced on each lane by that lane's number.
module os_lane_striper
    import ltssm_pkg::*;
(
    input  logic [127:0]           os_data,
    input  logic [1:0]             os_type,
    input  logic [3:0]             sym_idx,
    input  logic [2:0]             lane_shift,
    input  logic [6:0]             beat_bytes,
    output logic [BUS_WIDTH-1:0]   beat
);

`ifndef LANE_NUM_INSERT_EN
    // Without lane-number insertion the OS type has no effect on the data.
    logic unused_os_type;
    assign unused_os_type = ^os_type;
`endif

    // Walk every byte slot of the bus and pick the symbol it carries.
    always_comb begin
        logic [3:0] sym;
        logic [7:0] byte_val;
`ifdef LANE_NUM_INSERT_EN
        logic [4:0] lane_mask;
        logic [4:0] lane;
        logic       is_training;
`endif
        beat     = '0;
        sym      = '0;
        byte_val = '0;
`ifdef LANE_NUM_INSERT_EN
        lane_mask   = (5'd1 << lane_shift) - 5'd1;
        lane        = '0;
        is_training = (os_type == OS_TYPE_TS1) || (os_type == OS_TYPE_TS2);
`endif
        for (int k = 0; k < BUS_WIDTH / 8; k++) begin
            if (k < int'(beat_bytes)) begin
                sym      = sym_idx + 4'(k >> lane_shift);
                byte_val = os_data[{sym, 3'b000} +: 8];
`ifdef LANE_NUM_INSERT_EN
                lane = 5'(k) & lane_mask;
                if (is_training && (sym == 4'd2)) begin
                    byte_val = {3'b000, lane};
                end
`endif
                beat[8*k +: 8] = byte_val;
            end
        end
    end

endmodule

// File: rtl/os_encoder.sv
// os_encoder: TX-side ordered-set encoder.  Accepts one 16-symbol ordered
// set from the TX LTSSM, replicates it on every detected lane and streams
// it to the PIPE side as one or more lane-interleaved beats.  Generation
// and lane count are captured when the OS is accepted and stay fixed until
// the next accept.  A new OS can be taken on the final beat's handshake so
// consecutive ordered sets stream without a bubble.
// Build option LANE_NUM_INSERT_EN (handled in os_lane_striper): lane number
// insertion into symbol 2 of TS1/TS2 ordered sets.
module os_encoder
    import ltssm_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             gen,
    input  logic [4:0]             numberOfDetectedLanes,
    input  logic [127:0]           osIn,
    input  logic [1:0]             osType,
    input  logic                   osValid,
    output logic                   osReady,
    input  logic                   pipeReady,
    output logic [BUS_WIDTH-1:0]   dataOut,
    output logic                   dataValid,
    output logic                   lastBeat
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]             state;
    logic [127:0]           os_hold;
    logic [1:0]             type_hold;
    logic [2:0]             shift_hold;
    logic [6:0]             bytes_hold;
    logic [3:0]             sym_idx;

    logic [2:0]             accept_shift;
    logic [4:0]             syms_per_beat;
    logic                   in_send;
    logic                   final_beat;
    logic                   accept;
    logic                   advance;
    logic [BUS_WIDTH-1:0]   striped;

    // Symbols per lane per beat: beat bytes divided by the lane count.
    assign syms_per_beat = 5'(bytes_hold >> shift_hold);
    assign accept_shift  = lanes_to_shift(numberOfDetectedLanes);

    assign in_send    = (state == ST_SEND);
    assign final_beat = (({1'b0, sym_idx} + syms_per_beat) == 5'(OS_SYMBOLS));

    // The source may hand over a new OS when idle, or on the very cycle the
    // last beat of the current OS is taken downstream.  Held low in reset.
    assign osReady   = !reset && (!in_send || (final_beat && pipeReady));
    assign accept    = osReady && osValid;
    assign advance   = in_send && pipeReady;

    assign dataValid = in_send;
    assign lastBeat  = in_send && final_beat;
    assign dataOut   = in_send ? striped : '0;

    os_lane_striper u_striper (
        .os_data    (os_hold),
        .os_type    (type_hold),
        .sym_idx    (sym_idx),
        .lane_shift (shift_hold),
        .beat_bytes (bytes_hold),
        .beat       (striped)
    );

    // Capture an OS on accept, then step through it one beat per handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            os_hold    <= '0;
            type_hold  <= '0;
            shift_hold <= '0;
            bytes_hold <= '0;
            sym_idx    <= '0;
        end else if (accept) begin
            state      <= ST_SEND;
            os_hold    <= osIn;
            type_hold  <= osType;
            shift_hold <= accept_shift;
            bytes_hold <= 7'(beat_width(gen, accept_shift) >> 3);
            sym_idx    <= '0;
        end else if (advance) begin
            if (final_beat) begin
                state   <= ST_IDLE;
                sym_idx <= '0;
            end else begin
                sym_idx <= sym_idx + syms_per_beat[3:0];
            end
        end
    end

endmodule
